// File: rtl/addsub_arbiter_if.sv
// Request/result bus of the shared add/sub unit: NUM_REQ packed requesters in,
// one tagged result out, valid/ready on both sides.
interface addsub_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int data_size = 15,
    parameter int ID_W      = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_add_sub;
    logic [NUM_REQ*data_size-1:0] req_dataa;
    logic [NUM_REQ*data_size-1:0] req_datab;
    logic                         res_valid;
    logic                         res_ready;
    logic [ID_W-1:0]              res_id;
    logic [data_size:0]           result;

    modport slave (
        input  req_valid, req_add_sub, req_dataa, req_datab, res_ready,
        output req_ready, res_valid, res_id, result
    );

    modport master (
        output req_valid, req_add_sub, req_dataa, req_datab, res_ready,
        input  req_ready, res_valid, res_id, result
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one registered add/sub stage with a tagged result.
// Optional ADDSUB_ARB_SAT_EN: saturate to data_size bits and report sat_flag.
module addsub_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int data_size = 15,
    parameter int ID_W      = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    addsub_arbiter_if.slave  bus,
`ifdef ADDSUB_ARB_SAT_EN
    output logic             sat_flag,
`endif
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    localparam int W = data_size + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    idx;
    logic               grant_any;
    logic               issue_en;
    logic [NUM_REQ-1:0] ready_vec;

    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [W-1:0]       result_q;

    logic [data_size-1:0] op_a, op_b;
    logic [W-1:0]         ext_a, ext_b, sum, load_val;
    logic                 load_sat;

    // Search downward so the lowest offset from rr_ptr wins.
    always_comb begin
        issue_en  = !res_valid_q || bus.res_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (issue_en && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        ready_vec = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        op_a  = bus.req_dataa[grant_idx*data_size +: data_size];
        op_b  = bus.req_datab[grant_idx*data_size +: data_size];
        ext_a = {op_a[data_size-1], op_a};
        ext_b = {op_b[data_size-1], op_b};
        sum   = bus.req_add_sub[grant_idx] ? (ext_a + ext_b) : (ext_a + ~ext_b + W'(1));
        load_val = sum;
        load_sat = 1'b0;
`ifdef ADDSUB_ARB_SAT_EN
        // Top two bits disagree means the value left the data_size range.
        if (sum[W-1] ^ sum[W-2]) begin
            load_sat = 1'b1;
            load_val = sum[W-1] ? {2'b11, {(data_size-1){1'b0}}}
                                : {2'b00, {(data_size-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            result_q    <= '0;
            op_count    <= '0;
            rr_ptr      <= '0;
`ifdef ADDSUB_ARB_SAT_EN
            sat_flag    <= 1'b0;
`endif
        end else begin
            if (res_valid_q && bus.res_ready)
                op_count <= op_count + CNT_W'(1);
            if (grant_any) begin
                res_valid_q <= 1'b1;
                res_id_q    <= grant_idx;
                result_q    <= load_val;
                rr_ptr      <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
`ifdef ADDSUB_ARB_SAT_EN
                sat_flag    <= load_sat;
`endif
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.result    = result_q;
    assign busy          = res_valid_q || (|bus.req_valid);

endmodule
